// File: rtl/joypad_pkg.sv
// joypad_pkg
// Shared types and constants for the joypad I2C poller: FSM state encoding,
// bit-frame quarter indices, frame lengths, and the SCL/SDA decode for a
// given (state, quarter) position.
//
// Optional build macro: JOYPAD_DEBOUNCE_EN is consumed by joypad_poller; this
// package does not depend on it.
package joypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_AACK,
        ST_DATA,
        ST_MACK,
        ST_STOP
    } joypad_state_e;

    // Quarter positions inside one 4-quarter bit frame.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int unsigned START_QUARTERS = 2;
    localparam int unsigned STOP_QUARTERS  = 3;
    localparam int unsigned FRAME_BITS     = 8;
    localparam logic [2:0]  BIT_MSB        = 3'(FRAME_BITS - 1);

    localparam logic I2C_RD = 1'b1;

    // Returns {scl, sda} drive levels (1 = released) for a bus position.
    // SCL is low for q0/q1 and high for q2/q3 of every bit frame; the
    // transmitted bit only matters while sending the address byte.
    function automatic logic [1:0] frame_lines(joypad_state_e st, logic [1:0] q, logic tx_bit);
        logic [1:0] lines;
        lines = 2'b11;
        case (st)
            ST_START: lines = 2'b10;
            ST_ADDR:  lines = {q >= Q2, tx_bit};
            ST_AACK,
            ST_DATA,
            ST_MACK:  lines = {q >= Q2, 1'b1};
            ST_STOP: begin
                if (q == Q0) begin
                    lines = 2'b00;
                end else if (q == Q1) begin
                    lines = 2'b10;
                end else begin
                    lines = 2'b11;
                end
            end
            default:  lines = 2'b11;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/joypad_poller_if.sv
// joypad_poller_if
// Open-drain joypad I2C bus as seen from the poller.
//   joypad_scl_out : SCL drive, 0 pulls low, 1 releases
//   joypad_sda_out : SDA drive, 0 pulls low, 1 releases
//   joypad_sda_in  : resolved SDA pin level (asynchronous to clk)
// master: the poller; slave: the pad/expander side (or a bench model).
interface joypad_poller_if;
    logic joypad_scl_out;
    logic joypad_sda_out;
    logic joypad_sda_in;

    modport master (
        output joypad_scl_out,
        output joypad_sda_out,
        input  joypad_sda_in
    );

    modport slave (
        input  joypad_scl_out,
        input  joypad_sda_out,
        output joypad_sda_in
    );
endinterface

// File: rtl/quarter_tick.sv
// quarter_tick
// Divider producing a one-cycle tick every QUARTER clocks while not cleared.
//   clk, rst_n : system clock, async active-low reset
//   clear      : holds the count at 0 and suppresses the tick
//   tick       : high on the last cycle of each quarter period
module quarter_tick #(
    parameter int unsigned QUARTER = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    CW   = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [CW-1:0]  LAST = CW'(QUARTER - 1);

    logic [CW-1:0] cnt;

    assign tick = ~clear & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/joypad_poller.sv
// joypad_poller
// Periodically reads one byte from the joypad I2C expander
// (START, addr+R, ACK, data, NACK, STOP) and presents the pressed mask.
//   clk, rst_n : system clock, async active-low reset
//   enable     : polling allowed (looked at only when idle)
//   bus        : open-drain SCL/SDA drives and resolved SDA input
//   buttons    : pressed mask (inverse of the active-low expander byte)
//   valid      : one-cycle pulse per successful read
//   nack_err   : last transaction saw an address NACK
//   busy       : a transaction is in progress
// Build macro JOYPAD_DEBOUNCE_EN: buttons only update when two consecutive
// successful reads return the same byte.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | lines released, waiting for an enabled poll tick
// ST_START | 2 quarters SCL high / SDA low (start condition)
// ST_ADDR  | 8 bit frames shifting out {ADDR, R}
// ST_AACK  | 1 bit frame, SDA released, slave ACK sampled
// ST_DATA  | 8 bit frames, SDA released, data sampled MSB first
// ST_MACK  | 1 bit frame, SDA released (master NACK)
// ST_STOP  | 3 quarters: 00, 10, 11 on {SCL, SDA}
module joypad_poller
    import joypad_pkg::*;
#(
    parameter int unsigned QUARTER     = 5,
    parameter int unsigned POLL_CYCLES = 33333,
    parameter logic [6:0]  ADDR        = 7'h20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    joypad_poller_if.master    bus,
    output logic [7:0]         buttons,
    output logic               valid,
    output logic               nack_err,
    output logic               busy
);

    localparam int unsigned PW        = $clog2(POLL_CYCLES);
    localparam logic [7:0]  ADDR_BYTE = {ADDR, I2C_RD};

    joypad_state_e state, state_nxt;
    logic [1:0]    q_idx, q_nxt;
    logic [2:0]    bit_idx, bit_nxt;

    logic [PW-1:0] poll_cnt;
    logic          poll_tick;
    logic          q_tick;
    logic          q_clear;

    logic          sda_meta, sda_sync;
    logic          sample_ack, sample_bit, finish;
    logic          nack_seen;
    logic [7:0]    rx_byte;
    logic          scl_q, sda_q;
    logic [1:0]    lines_nxt;

`ifdef JOYPAD_DEBOUNCE_EN
    logic [7:0]    cand_byte;
`endif

    // Poll timer: free-running, wrap cycle is the tick.
    assign poll_tick = (poll_cnt == PW'(POLL_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (poll_tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // SDA pin is asynchronous; released level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= bus.joypad_sda_in;
            sda_sync <= sda_meta;
        end
    end

    assign q_clear = (state == ST_IDLE);

    quarter_tick #(
        .QUARTER (QUARTER)
    ) u_quarter_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (q_clear),
        .tick  (q_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            q_idx   <= Q0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            q_idx   <= q_nxt;
            bit_idx <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        q_nxt      = q_idx;
        bit_nxt    = bit_idx;
        sample_ack = 1'b0;
        sample_bit = 1'b0;
        finish     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (poll_tick && enable) begin
                    state_nxt = ST_START;
                    q_nxt     = Q0;
                    bit_nxt   = BIT_MSB;
                end
            end

            ST_START: begin
                if (q_tick) begin
                    if (q_idx == 2'(START_QUARTERS - 1)) begin
                        state_nxt = ST_ADDR;
                        q_nxt     = Q0;
                        bit_nxt   = BIT_MSB;
                    end else begin
                        q_nxt = q_idx + 2'd1;
                    end
                end
            end

            ST_ADDR, ST_AACK, ST_DATA, ST_MACK: begin
                if (q_tick) begin
                    q_nxt = q_idx + 2'd1;
                    // Sample at the end of q2: SCL has been high a full
                    // quarter, which covers the synchronizer latency.
                    if (q_idx == Q2) begin
                        sample_ack = (state == ST_AACK);
                        sample_bit = (state == ST_DATA);
                    end
                    if (q_idx == Q3) begin
                        q_nxt = Q0;
                        case (state)
                            ST_ADDR: begin
                                if (bit_idx == 3'd0) begin
                                    state_nxt = ST_AACK;
                                end else begin
                                    bit_nxt = bit_idx - 3'd1;
                                end
                            end
                            ST_AACK: begin
                                state_nxt = nack_seen ? ST_STOP : ST_DATA;
                                bit_nxt   = BIT_MSB;
                            end
                            ST_DATA: begin
                                if (bit_idx == 3'd0) begin
                                    state_nxt = ST_MACK;
                                end else begin
                                    bit_nxt = bit_idx - 3'd1;
                                end
                            end
                            default: begin
                                state_nxt = ST_STOP;
                            end
                        endcase
                    end
                end
            end

            ST_STOP: begin
                if (q_tick) begin
                    if (q_idx == 2'(STOP_QUARTERS - 1)) begin
                        state_nxt = ST_IDLE;
                        q_nxt     = Q0;
                        finish    = 1'b1;
                    end else begin
                        q_nxt = q_idx + 2'd1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                q_nxt     = Q0;
            end
        endcase
    end

    // Line drives are registered from the next-state decode so they are
    // glitch-free and change exactly at the start of each quarter.
    assign lines_nxt = frame_lines(state_nxt, q_nxt, ADDR_BYTE[bit_nxt]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= lines_nxt[1];
            sda_q <= lines_nxt[0];
        end
    end

    assign bus.joypad_scl_out = scl_q;
    assign bus.joypad_sda_out = sda_q;
    assign busy               = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nack_seen <= 1'b0;
            rx_byte   <= '0;
            buttons   <= '0;
            valid     <= 1'b0;
            nack_err  <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
            cand_byte <= 8'hFF;
`endif
        end else begin
            valid <= 1'b0;
            if (sample_ack) begin
                nack_seen <= sda_sync;
            end
            if (sample_bit) begin
                rx_byte <= {rx_byte[6:0], sda_sync};
            end
            if (finish) begin
                if (nack_seen) begin
                    nack_err <= 1'b1;
                end else begin
                    valid    <= 1'b1;
                    nack_err <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
                    if (rx_byte == cand_byte) begin
                        buttons <= ~rx_byte;
                    end
                    cand_byte <= rx_byte;
`else
                    buttons <= ~rx_byte;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_joypad_poller.sv
// tb_joypad_poller
// Randomized bench for joypad_poller. A transaction-level reference model
// predicts when each poll starts and ends (77 or 41 quarters), what busy,
// valid, nack_err and buttons must show each cycle, and a bus monitor with a
// bit-level expander model decodes SCL/SDA and checks the frame contents.
// Honours JOYPAD_DEBOUNCE_EN in the expected button mask.
module tb_joypad_poller;

    localparam int unsigned Q          = 4;
    localparam int unsigned P          = 200;
    localparam logic [6:0]  DEV_ADDR   = 7'h20;
    localparam logic [7:0]  ADDR_RD    = {DEV_ADDR, 1'b1};
    localparam int          L_OK       = 77 * Q;
    localparam int          L_NACK     = 41 * Q;
    localparam int          RST_TXN    = 8;
    // START 2 + addr/ack 36 + four data bits 16 + one quarter: q1 of DATA bit 3
    localparam int          RST_OFS    = (2 + 36 + 16 + 1) * Q;
    localparam int          RUN_CYCLES = 16000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       slave_sda = 1'b1;
    logic [7:0] buttons;
    logic       valid, nack_err, busy;

    always #5 clk = ~clk;

    joypad_poller_if bus ();
    assign bus.joypad_sda_in = bus.joypad_sda_out & slave_sda;

    joypad_poller #(
        .QUARTER     (Q),
        .POLL_CYCLES (P),
        .ADDR        (DEV_ADDR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus),
        .buttons  (buttons),
        .valid    (valid),
        .nack_err (nack_err),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int         cyc;
    bit         m_pending;
    int         m_start, m_end, m_idx;
    bit         m_ok;
    logic [7:0] m_byte, last_byte;
    logic [7:0] exp_buttons, exp_cand;
    bit         exp_nack;
    int         txn_idx = 0;
    bit         did_rst = 0;

    bit         d_present [6];
    logic [7:0] d_byte    [6];

    // bus monitor / expander model state
    bit          prev_scl, prev_sda, mon_in;
    int          mon_nbits, fall_cnt;
    logic [31:0] mon_bits;

    task automatic model_reset();
        cyc         = 0;
        m_pending   = 0;
        m_start     = 0;
        m_end       = 0;
        exp_buttons = 8'h00;
        exp_nack    = 0;
        exp_cand    = 8'hFF;
        prev_scl    = 1;
        prev_sda    = 1;
        mon_in      = 0;
        mon_nbits   = 0;
        mon_bits    = '0;
        fall_cnt    = 0;
        slave_sda   = 1'b1;
    endtask

    task automatic cycle_step();
        bit exp_valid;
        bit exp_busy;
        bit scl, sda;

        cyc++;
        if (did_rst && cyc > 2 * P && $urandom_range(0, 99) == 0)
            enable = ($urandom_range(0, 3) != 0);

        exp_valid = 0;
        if (m_pending && cyc == m_end) begin
            m_pending = 0;
            if (m_ok) begin
                exp_valid = 1;
                exp_nack  = 0;
`ifdef JOYPAD_DEBOUNCE_EN
                if (m_byte == exp_cand) exp_buttons = ~m_byte;
                exp_cand = m_byte;
`else
                exp_buttons = ~m_byte;
`endif
            end else begin
                exp_nack = 1;
            end
        end

        if (!m_pending && (cyc % P) == P - 1 && enable) begin
            m_pending = 1;
            m_start   = cyc + 1;
            m_idx     = txn_idx;
            if (txn_idx < 6) begin
                m_ok   = d_present[txn_idx];
                m_byte = d_byte[txn_idx];
            end else begin
                m_ok   = (txn_idx == RST_TXN) || (txn_idx == RST_TXN + 1) || ($urandom_range(0, 3) != 0);
                m_byte = ($urandom_range(0, 1) == 1) ? last_byte : 8'($urandom);
            end
            if (m_ok) last_byte = m_byte;
            m_end = m_start + (m_ok ? L_OK : L_NACK);
            txn_idx++;
        end

        exp_busy = m_pending && (cyc >= m_start);
        check("busy", busy, exp_busy);
        check("valid", valid, exp_valid);
        check("buttons", buttons, exp_buttons);
        check("nack_err", nack_err, exp_nack);
        if (!exp_busy) begin
            check("scl_idle", bus.joypad_scl_out, 1);
            check("sda_idle", bus.joypad_sda_out, 1);
        end

        scl = bus.joypad_scl_out;
        sda = bus.joypad_sda_in;
        if (prev_scl && scl && prev_sda && !sda) begin
            check("start_cycle", cyc, m_start);
            mon_in    = 1;
            mon_nbits = 0;
            mon_bits  = '0;
            fall_cnt  = 0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            check("stop_cycle", cyc, m_end - Q);
            if (m_ok) begin
                check("nbits_ok", mon_nbits, 19);
                check("addr_byte", mon_bits[18:11], ADDR_RD);
                check("slave_ack", mon_bits[10], 0);
                check("data_byte", mon_bits[9:2], m_byte);
                check("master_nack", mon_bits[1], 1);
            end else begin
                check("nbits_nack", mon_nbits, 10);
                check("addr_byte", mon_bits[9:2], ADDR_RD);
                check("absent_ack", mon_bits[1], 1);
            end
            mon_in = 0;
        end
        if (!prev_scl && scl && mon_in) begin
            mon_bits = {mon_bits[30:0], sda};
            mon_nbits++;
        end
        // Expander: changes SDA only after SCL falls. Fall 9 opens the ACK
        // frame, falls 10..17 open data bits 7..0.
        if (prev_scl && !scl && mon_in) begin
            fall_cnt++;
            if (m_ok && fall_cnt == 9)
                slave_sda = 1'b0;
            else if (m_ok && fall_cnt >= 10 && fall_cnt <= 17)
                slave_sda = m_byte[17 - fall_cnt];
            else
                slave_sda = 1'b1;
        end
        prev_scl = scl;
        prev_sda = sda;
    endtask

    initial begin
        d_present = '{1, 0, 1, 1, 1, 1};
        d_byte    = '{8'hFE, 8'h00, 8'h7F, 8'hFE, 8'hFD, 8'hFD};
        last_byte = 8'hFE;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_scl", bus.joypad_scl_out, 1);
        check("rst_sda", bus.joypad_sda_out, 1);
        check("rst_buttons", buttons, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_nack_err", nack_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < RUN_CYCLES; i++) begin
            @(negedge clk);
            cycle_step();
            if (!did_rst && m_pending && m_idx == RST_TXN && cyc == m_start + RST_OFS) begin
                check("pre_rst_scl_low", bus.joypad_scl_out, 0);
                rst_n = 1'b0;
                #1;
                check("mid_rst_scl", bus.joypad_scl_out, 1);
                check("mid_rst_sda", bus.joypad_sda_out, 1);
                check("mid_rst_buttons", buttons, 8'h00);
                check("mid_rst_valid", valid, 0);
                check("mid_rst_nack_err", nack_err, 0);
                check("mid_rst_busy", busy, 0);
                repeat (3) @(negedge clk);
                rst_n   = 1'b1;
                did_rst = 1;
                model_reset();
            end
        end

        check("reset_pulse_reached", did_rst, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
